// File: rtl/snooze_countdown.sv
// Snooze timer: loads whole minutes, counts MM:SS down on the shared 1 Hz tick,
// and pulses expired for one cycle when 00:01 reaches 00:00.
module snooze_countdown #(
    parameter int MIN_W   = 7,
    parameter int MAX_MIN = 99,
    parameter int DEF_MIN = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             start,
    input  logic             cancel,
    input  logic             pause,
    input  logic [MIN_W-1:0] load_min,
    output logic [MIN_W-1:0] min,
    output logic [5:0]       sec,
    output logic             running,
    output logic             paused,
    output logic             expired
);

    localparam logic [MIN_W-1:0] MAX_LOAD = MIN_W'(MAX_MIN);
    localparam logic [MIN_W-1:0] DEF_LOAD = MIN_W'(DEF_MIN);
    localparam logic [MIN_W-1:0] ONE_MIN  = MIN_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [MIN_W-1:0] min_reg, min_next;
    logic [5:0]       sec_reg, sec_next;
    logic             expired_reg, expired_next;
    logic [MIN_W-1:0] load_value;

    // Zero selects the default snooze length; oversized loads saturate.
    always_comb begin
        if (load_min == '0)
            load_value = DEF_LOAD;
        else if (load_min > MAX_LOAD)
            load_value = MAX_LOAD;
        else
            load_value = load_min;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            min_reg     <= '0;
            sec_reg     <= '0;
            expired_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            min_reg     <= min_next;
            sec_reg     <= sec_next;
            expired_reg <= expired_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        min_next     = min_reg;
        sec_next     = sec_reg;
        expired_next = 1'b0;
        if (cancel) begin
            state_next = IDLE;
            min_next   = '0;
            sec_next   = '0;
        end else if (start) begin
            state_next = RUN;
            min_next   = load_value;
            sec_next   = '0;
        end else if (pause) begin
            if (state_reg == RUN)
                state_next = PAUSED;
            else if (state_reg == PAUSED)
                state_next = RUN;
        end else if (tick && state_reg == RUN) begin
            if (sec_reg != 6'd0) begin
                sec_next = sec_reg - 6'd1;
                if (min_reg == '0 && sec_reg == 6'd1) begin
                    state_next   = IDLE;
                    expired_next = 1'b1;
                end
            end else if (min_reg != '0) begin
                sec_next = 6'd59;
                min_next = min_reg - ONE_MIN;
            end else begin
                // 00:00 in RUN cannot be reached; fall back to idle silently.
                state_next = IDLE;
            end
        end
    end

    assign min     = min_reg;
    assign sec     = sec_reg;
    assign running = (state_reg == RUN);
    assign paused  = (state_reg == PAUSED);
    assign expired = expired_reg;

endmodule

// File: tb/tb_snooze_countdown.sv
// Directed bench for snooze_countdown: hand-computed MM:SS values after each request.
module tb_snooze_countdown;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic       cancel = 1'b0;
    logic       pause = 1'b0;
    logic [6:0] load_min = '0;
    logic [6:0] min;
    logic [5:0] sec;
    logic       running;
    logic       paused;
    logic       expired;

    int vectors = 0;
    int miscompares = 0;

    snooze_countdown #(.MIN_W(7), .MAX_MIN(99), .DEF_MIN(9)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .start    (start),
        .cancel   (cancel),
        .pause    (pause),
        .load_min (load_min),
        .min      (min),
        .sec      (sec),
        .running  (running),
        .paused   (paused),
        .expired  (expired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s = %0d", tag, obs);
        end
    endtask

    // Apply one set of requests for exactly one clock edge; outputs settle 1 ns later.
    task automatic cyc(input logic t, input logic s, input logic c, input logic p,
                       input logic [6:0] lm);
        tick = t; start = s; cancel = c; pause = p; load_min = lm;
        @(posedge clk);
        #1;
        tick = 1'b0; start = 1'b0; cancel = 1'b0; pause = 1'b0; load_min = '0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 7'd0);
    endtask

    task automatic chk_time(input string tag, input int m, input int s);
        chk({tag, ".min"}, int'(min), m);
        chk({tag, ".sec"}, int'(sec), s);
    endtask

    initial begin
        int expired_seen;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        chk_time("in_reset", 0, 0);
        chk("in_reset.running", int'(running), 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk_time("after_reset", 0, 0);
        chk("after_reset.running", int'(running), 0);
        chk("after_reset.paused", int'(paused), 0);
        chk("after_reset.expired", int'(expired), 0);
        ticks(3);
        chk_time("idle_ticks", 0, 0);
        chk("idle_ticks.running", int'(running), 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 7'd0);
        chk("idle_pause.paused", int'(paused), 0);

        // Basic countdown from 02:00
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 7'd2);
        chk_time("load2", 2, 0);
        chk("load2.running", int'(running), 1);
        ticks(1);
        chk_time("borrow", 1, 59);
        expired_seen = 0;
        for (int i = 0; i < 118; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 7'd0);
            if (expired) expired_seen++;
        end
        chk("early_expired_count", expired_seen, 0);
        chk_time("tick119", 0, 1);
        chk("tick119.running", int'(running), 1);
        ticks(1);
        chk_time("tick120", 0, 0);
        chk("tick120.running", int'(running), 0);
        chk("tick120.expired", int'(expired), 1);
        ticks(1);
        chk("post_expiry.expired", int'(expired), 0);
        chk_time("post_expiry", 0, 0);

        // Default and clamp loads
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 7'd0);
        chk_time("load_default", 9, 0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 7'd120);
        chk_time("load_clamp120", 99, 0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 7'd100);
        chk_time("load_clamp100", 99, 0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 7'd99);
        chk_time("load99", 99, 0);
        ticks(60);
        chk_time("load99_60ticks", 98, 0);

        // Pause
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 7'd2);
        ticks(30);
        chk_time("at_0130", 1, 30);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 7'd0);
        chk("pause.paused", int'(paused), 1);
        chk("pause.running", int'(running), 0);
        ticks(10);
        chk_time("paused_ticks", 1, 30);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 7'd0);
        chk("resume.running", int'(running), 1);
        ticks(1);
        chk_time("resume_tick", 1, 29);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 7'd0);
        chk("pause_tick.paused", int'(paused), 1);
        chk_time("pause_tick", 1, 29);

        // Priority
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 7'd1);
        ticks(15);
        chk_time("at_0045", 0, 45);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 7'd0);
        chk("p45.paused", int'(paused), 1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 7'd3);
        chk_time("restart_paused", 3, 0);
        chk("restart_paused.running", int'(running), 1);
        chk("restart_paused.paused", int'(paused), 0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 7'd5);
        chk_time("start_tick", 5, 0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 7'd4);
        chk_time("cancel_start", 0, 0);
        chk("cancel_start.running", int'(running), 0);
        chk("cancel_start.expired", int'(expired), 0);
        ticks(1);
        chk("cancel_next.expired", int'(expired), 0);

        // Asynchronous reset at 00:01
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 7'd1);
        ticks(59);
        chk_time("at_0001", 0, 1);
        #1 rst_n = 1'b0;
        #1;
        chk_time("async_reset", 0, 0);
        chk("async_reset.running", int'(running), 0);
        #1 rst_n = 1'b1;
        ticks(1);
        chk("after_areset_tick.expired", int'(expired), 0);
        chk("after_areset_tick.running", int'(running), 0);
        chk_time("after_areset_tick", 0, 0);
        ticks(1);
        chk("after_areset_tick2.expired", int'(expired), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/snooze_countdown.md
Name: snooze_countdown

Overview:
Down-counting MM:SS timer for the alarm-clock snooze function. It counts in the opposite direction to the up-counting time-of-day chain and uses the same one-cycle enable ("tick", 1 Hz) that drives that chain. It borrows seconds into minutes and reports expiry with a one-cycle pulse. It sits beside the time counters and feeds the alarm-sounding logic.

Parameters:
MIN_W, 7, width of the minutes field and of load_min
MAX_MIN, 99, largest loadable minutes value; larger loads clamp to this
DEF_MIN, 9, minutes loaded when start arrives with load_min == 0

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous reset, active-low
tick  input  1  one-cycle 1 Hz enable, same source as the time-of-day counter carry-in
start  input  1  one-cycle request: load minutes and begin counting
cancel  input  1  one-cycle request: abort and return to idle
pause  input  1  one-cycle request: toggle RUN <-> PAUSED
load_min  input  MIN_W  minutes to load on start
min  output  MIN_W  remaining minutes (registered)
sec  output  6  remaining seconds, 0..59 (registered)
running  output  1  high in RUN state
paused  output  1  high in PAUSED state
expired  output  1  one-cycle pulse on the clock after the final decrement

Behaviour:
- Reset (rst_n = 0, asynchronous): state IDLE; min = 0, sec = 0, running = 0, paused = 0, expired = 0.
- States: IDLE, RUN, PAUSED. All outputs are registered; running/paused decode the state register.
- Request priority per edge: cancel > start > pause > tick.
- cancel (any state): next state IDLE; min = 0, sec = 0; no expired pulse.
- start (any state, no cancel): loaded minutes = DEF_MIN if load_min == 0, MAX_MIN if load_min > MAX_MIN, load_min otherwise. min = loaded minutes, sec = 0, state RUN. A tick in the same cycle is ignored. start during RUN or PAUSED restarts the timer.
- pause: RUN -> PAUSED, PAUSED -> RUN. pause is ignored in IDLE. A tick in the same cycle is ignored.
- tick in RUN only. tick is ignored in IDLE and PAUSED.
  - sec > 0: sec - 1.
  - sec == 0 and min > 0: sec = 59, min - 1 (borrow).
  - min == 0 and sec == 1: sec = 0, state IDLE, expired = 1 on the next cycle for exactly one cycle.
- A RUN state with 00:00 is unreachable: start always loads at least 1 minute.
- Latency: outputs update on the clock edge that samples the request or tick. The expired register is set on the same edge as the 00:01 -> 00:00 transition, so it is visible for the cycle that follows.
- expired is never high for two consecutive cycles. A start on the cycle where expired is high is accepted normally.
- Duration check: loading N minutes then giving N*60 ticks in RUN produces exactly one expired pulse.
- Width rules: sec never leaves 0..59. min never exceeds MAX_MIN. No wrap below 00:00.
- Reset asserted mid-count: immediate return to reset values, no expired pulse. After rst_n rises, the block stays IDLE until the next start.

Test Plan:
- Reset: hold rst_n = 0, then release -> min = 0, sec = 0, running = 0, expired = 0. Ticks alone keep all values at 0.
- Basic countdown: start with load_min = 2 -> 02:00, running = 1. One tick -> 01:59. Give 119 ticks total -> 00:01. 120th tick -> 00:00, IDLE, expired high for exactly one cycle.
- Default and clamp loads: start with load_min = 0 -> 09:00. start with load_min = 120 -> 99:00. 60 ticks after the 99:00 load -> 98:00.
- Pause: at 01:30, pause -> paused = 1. 10 ticks -> still 01:30. pause -> RUN. 1 tick -> 01:29. pause and tick in the same cycle -> PAUSED, value unchanged.
- Priority: cancel + start in the same cycle during RUN -> IDLE, 00:00, no expired pulse. start + tick in the same cycle -> loaded value, not decremented. start during PAUSED at 00:45 with load_min = 3 -> 03:00, RUN.
- Asynchronous reset mid-run: at 00:01, drop rst_n between clock edges -> outputs clear immediately. The following tick produces no expired pulse.
